// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//   Memory-side responder for the data cache's tagged request/response protocol.
//   Accepts one LOAD or STORE per cycle. In the same cycle it returns the
//   lowest free transaction tag, or 0 if it rejects the request. The block
//   returns exactly MEM_LATENCY cycles later, tagged, on the registered
//   completion outputs.
//
//   Optional build macro DMEM_STALL_EN adds a free-running 3-bit cycle counter.
//   When the counter reads 7, the responder rejects every request, so the
//   cache's retry paths get exercised.
// -----------------------------------------------------------------------------
module dmem_responder #(
   parameter int MEM_LATENCY = 4,     // accept-to-return cycles, 1..15
   parameter int NUM_TAGS    = 15,    // usable tags 1..NUM_TAGS, 1..15
   parameter int MEM_DEPTH   = 1024   // 64-bit words, power of 2
) (
   input  logic        clock,
   input  logic        reset,              // synchronous, active-low
   input  logic [1:0]  proc2mem_command,
   input  logic [63:0] proc2mem_addr,
   input  logic [63:0] proc2mem_data,
   output logic [3:0]  mem2proc_response,
   output logic [63:0] mem2proc_data,
   output logic [3:0]  mem2proc_tag
);

   localparam int IDX_W = $clog2(MEM_DEPTH);

   // Command encoding; 2'b11 is not a member and therefore behaves as NONE.
   typedef enum logic [1:0] {
      CMD_NONE  = 2'b00,
      CMD_LOAD  = 2'b01,
      CMD_STORE = 2'b10
   } cmd_e;

   typedef struct packed {
      logic [3:0]  tag;
      logic [63:0] data;
   } pipe_entry_t;

   logic [IDX_W-1:0]  idx;
   logic              is_load;
   logic              is_store;
   logic              stall;
   logic              accept;
   logic [3:0]        alloc_tag;
   logic [3:0]        done_tag;
   logic [NUM_TAGS:1] busy;
   logic [NUM_TAGS:1] busy_next;
   logic [63:0]       mem [MEM_DEPTH];
   pipe_entry_t       pipe [MEM_LATENCY];
   pipe_entry_t       new_entry;
   logic              unused_addr_bits;

   assign idx      = proc2mem_addr[3 +: IDX_W];
   assign is_load  = (proc2mem_command == CMD_LOAD);
   assign is_store = (proc2mem_command == CMD_STORE);

   // Byte offset and bits above the index never select anything.
   assign unused_addr_bits = ^{proc2mem_addr[63:3+IDX_W], proc2mem_addr[2:0]};

`ifdef DMEM_STALL_EN
   logic [2:0] stall_cnt;

   // Free-running stall counter; rejects all requests on its all-ones phase.
   always_ff @(posedge clock) begin
      if (!reset) stall_cnt <= 3'd0;
      else        stall_cnt <= stall_cnt + 3'd1;
   end

   assign stall = (stall_cnt == 3'd7);
`else
   assign stall = 1'b0;
`endif

   // Lowest-numbered free tag; 0 when every tag is busy.
   always_comb begin
      // NOTE: defaulting every always_comb output first keeps all paths assigned, so no latch is inferred.
      alloc_tag = 4'd0;
      // Scanning downward lets the lowest free tag be the last, winning write.
      for (int t = NUM_TAGS; t >= 1; t--) begin
         if (!busy[t]) alloc_tag = 4'(t);
      end
   end

   // Same-cycle tag response; gated by reset so nothing is accepted while in reset.
   assign mem2proc_response = (reset && (is_load || is_store) && !stall) ? alloc_tag : 4'd0;
   assign accept            = (mem2proc_response != 4'd0);

   // The tag in the last pipeline stage completes this cycle and frees at the edge.
   assign done_tag = pipe[MEM_LATENCY-1].tag;

   // Busy bitmap update: release the completing tag, claim the accepted one.
   always_comb begin
      busy_next = busy;
      for (int t = 1; t <= NUM_TAGS; t++) begin
         if (done_tag == 4'(t))                  busy_next[t] = 1'b0;
         if (accept && mem2proc_response == 4'(t)) busy_next[t] = 1'b1;
      end
   end

   // Busy bitmap register; reset forgets every in-flight tag.
   always_ff @(posedge clock) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (!reset) busy <= '0;
      else        busy <= busy_next;
   end

   // Backing array write port; only accepted stores write.
   always_ff @(posedge clock) begin
      // NOTE: the array is deliberately not reset, so its contents survive reset and it maps to plain RAM.
      if (accept && is_store) mem[idx] <= proc2mem_data;
   end

   // Stores carry their own data. Loads snapshot the array before this edge's write,
   // which never aliases because only one request is accepted per cycle.
   always_comb begin
      new_entry = '0;
      if (accept) begin
         new_entry.tag  = mem2proc_response;
         new_entry.data = is_store ? proc2mem_data : mem[idx];
      end
   end

   // Completion shift register; the last stage drives the outputs directly.
   always_ff @(posedge clock) begin
      if (!reset) begin
         for (int i = 0; i < MEM_LATENCY; i++) pipe[i] <= '0;
      end else begin
         pipe[0] <= new_entry;
         for (int i = 1; i < MEM_LATENCY; i++) pipe[i] <= pipe[i-1];
      end
   end

   assign mem2proc_tag  = pipe[MEM_LATENCY-1].tag;
   assign mem2proc_data = pipe[MEM_LATENCY-1].data;

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
//   Scoreboard bench for dmem_responder with MEM_LATENCY=4 and NUM_TAGS=2.
//   Each accepted request pushes its expected {tag, data, due cycle} onto a
//   queue. The entry is popped and compared when its completion is due.
//   Honours DMEM_STALL_EN when the bundle is built with that macro.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

   localparam int LAT   = 4;
   localparam int NT    = 2;
   localparam int DEPTH = 1024;

   localparam logic [1:0] C_NONE  = 2'b00;
   localparam logic [1:0] C_LOAD  = 2'b01;
   localparam logic [1:0] C_STORE = 2'b10;

   logic        clock;
   logic        reset;
   logic [1:0]  cmd;
   logic [63:0] addr;
   logic [63:0] wdata;
   logic [3:0]  resp;
   logic [3:0]  tag;
   logic [63:0] rdata;

   dmem_responder #(
      .MEM_LATENCY (LAT),
      .NUM_TAGS    (NT),
      .MEM_DEPTH   (DEPTH)
   ) dut (
      .clock             (clock),
      .reset             (reset),
      .proc2mem_command  (cmd),
      .proc2mem_addr     (addr),
      .proc2mem_data     (wdata),
      .mem2proc_response (resp),
      .mem2proc_data     (rdata),
      .mem2proc_tag      (tag)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   typedef struct {
      logic [3:0]  tag;
      logic [63:0] data;
      int          due;
   } exp_t;

   exp_t        sb [$];
   logic [63:0] m_mem [DEPTH];
   logic [15:0] m_busy;
   logic [2:0]  m_cnt;
   int          cyc;
   bit          model_valid;
   int          n_checks;
   int          n_errors;
   logic [3:0]  obs_resp;
   logic [3:0]  obs_tag;
   logic [63:0] obs_data;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   function automatic logic [3:0] model_alloc();
      for (int t = 1; t <= NT; t++) if (!m_busy[t]) return 4'(t);
      return 4'd0;
   endfunction

   // One clock cycle. Drive the inputs, sample and check at the negedge,
   // then advance the model at the rising edge.
   task automatic step(input logic rst_v, input logic [1:0] c, input logic [63:0] a,
                       input logic [63:0] d);
      logic [3:0] exp_resp;
      logic       stall;
      exp_t       ent;
      int         idx;
      reset = rst_v;
      cmd   = c;
      addr  = a;
      wdata = d;
      stall = 1'b0;
`ifdef DMEM_STALL_EN
      stall = (m_cnt == 3'd7);
`endif
      exp_resp = (rst_v && (c == C_LOAD || c == C_STORE) && !stall) ? model_alloc() : 4'd0;
      @(negedge clock);
      obs_resp = resp;
      obs_tag  = tag;
      obs_data = rdata;
      if (model_valid) begin
         check("response", resp, exp_resp);
         if (sb.size() > 0 && sb[0].due == cyc) begin
            check("cpl_tag", tag, sb[0].tag);
            check("cpl_data", rdata, sb[0].data);
         end else begin
            check("idle_tag", tag, 4'd0);
            check("idle_data", rdata, 64'd0);
         end
      end
      @(posedge clock);
      if (!rst_v) begin
         m_busy = '0;
         sb.delete();
         m_cnt = 3'd0;
         model_valid = 1'b1;
      end else if (model_valid) begin
         if (sb.size() > 0 && sb[0].due == cyc) begin
            m_busy[sb[0].tag] = 1'b0;
            void'(sb.pop_front());
         end
         if (exp_resp != 4'd0) begin
            idx = int'(a[12:3]);
            m_busy[exp_resp] = 1'b1;
            ent.tag  = exp_resp;
            ent.data = (c == C_STORE) ? d : m_mem[idx];
            ent.due  = cyc + LAT;
            if (c == C_STORE) m_mem[idx] = d;
            sb.push_back(ent);
         end
         m_cnt = m_cnt + 3'd1;
      end
      cyc++;
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b1, C_NONE, 64'd0, 64'd0);
   endtask

   task automatic do_reset();
      step(1'b0, C_LOAD, 64'h40, 64'd0);
      step(1'b0, C_LOAD, 64'h40, 64'd0);
   endtask

   // Re-present a request until it is accepted, with a bounded number of tries.
   task automatic issue(input logic [1:0] c, input logic [63:0] a, input logic [63:0] d);
      int tries = 0;
      do begin
         step(1'b1, c, a, d);
         tries++;
      end while (obs_resp == 4'd0 && tries < 64);
      if (obs_resp == 4'd0) check("issue_timeout", obs_resp, 4'd1);
   endtask

   task automatic drain();
      int w = 0;
      while (sb.size() > 0 && w < 3 * LAT + 4) begin
         idle(1);
         w++;
      end
      check("drain", sb.size(), 0);
   endtask

   localparam logic [63:0] D_T2 = 64'hDEADBEEF_CAFEF00D;
   localparam logic [63:0] D_T4 = 64'h0123_4567_89AB_CDEF;
   localparam logic [63:0] D_T5 = 64'hA5A5_0000_FFFF_5A5A;

   initial begin
      logic [3:0]  t3_exp [5];
      logic [63:0] ra;
      reset = 1'b0;
      cmd   = C_NONE;
      addr  = '0;
      wdata = '0;
      n_checks = 0;
      n_errors = 0;
      cyc = 0;
      m_busy = '0;
      m_cnt = 3'd0;
      model_valid = 1'b0;
      for (int i = 0; i < DEPTH; i++) m_mem[i] = 64'd0;
      t3_exp = '{4'd1, 4'd2, 4'd0, 4'd0, 4'd0};

      @(posedge clock);
      #1;
      do_reset();
      check("rst_tag", tag, 4'd0);
      check("rst_data", rdata, 64'd0);

      // Zero the words the scripted and random traffic reads.
      for (int i = 0; i < 32; i++) issue(C_STORE, 64'(i) << 3, 64'd0);
      drain();

      // A single load returns its tag and the cleared word after the latency.
      do_reset();
      idle(1);
      step(1'b1, C_LOAD, 64'h40, 64'd0);
      check("t1_resp", obs_resp, 4'd1);
      idle(3);
      check("t1_quiet", obs_tag, 4'd0);
      idle(1);
      check("t1_tag", obs_tag, 4'd1);
      check("t1_data", obs_data, 64'd0);

      // A store followed by a load of the same word.
      do_reset();
      idle(1);
      step(1'b1, C_STORE, 64'h80, D_T2);
      check("t2_resp_st", obs_resp, 4'd1);
      step(1'b1, C_LOAD, 64'h80, 64'd0);
      check("t2_resp_ld", obs_resp, 4'd2);
      idle(3);
      check("t2_tag1", obs_tag, 4'd1);
      check("t2_data1", obs_data, D_T2);
      idle(1);
      check("t2_tag2", obs_tag, 4'd2);
      check("t2_data2", obs_data, D_T2);

      // Tag exhaustion. The completing tag is still busy in its completion
      // cycle and only becomes free the cycle after.
      do_reset();
      idle(1);
      for (int k = 0; k < 5; k++) begin
         step(1'b1, C_LOAD, 64'h48 + 64'(k) * 8, 64'd0);
         check("t3_resp", obs_resp, t3_exp[k]);
      end
      check("t3_cpl5", obs_tag, 4'd1);
      step(1'b1, C_LOAD, 64'h40, 64'd0);
      check("t3_retry", obs_resp, 4'd1);
      drain();

      // Reset mid-flight drops both tags; stored data survives.
      do_reset();
      idle(1);
      step(1'b1, C_STORE, 64'h100, D_T4);
      check("t4_resp_st", obs_resp, 4'd1);
      step(1'b1, C_LOAD, 64'h100, 64'd0);
      check("t4_resp_ld", obs_resp, 4'd2);
      step(1'b0, C_LOAD, 64'h100, 64'd0);
      check("t4_resp_rst", obs_resp, 4'd0);
      idle(1);
      check("t4_quiet4", obs_tag, 4'd0);
      step(1'b1, C_LOAD, 64'h100, 64'd0);
      check("t4_resp_new", obs_resp, 4'd1);
      check("t4_quiet5", obs_tag, 4'd0);
      for (int k = 0; k < 3; k++) begin
         idle(1);
         check("t4_quiet", obs_tag, 4'd0);
      end
      idle(1);
      check("t4_tag", obs_tag, 4'd1);
      check("t4_data", obs_data, D_T4);

      // The index wraps modulo depth, and the byte offset is ignored.
      do_reset();
      idle(1);
      step(1'b1, C_STORE, 64'h8, D_T5);
      step(1'b1, C_LOAD, 64'hFFFF_0000_0000_200D, 64'd0);
      check("t5_resp", obs_resp, 4'd2);
      idle(4);
      check("t5_tag", obs_tag, 4'd2);
      check("t5_data", obs_data, D_T5);

      // Random traffic, including the 2'b11 command, with a scrambled address.
      for (int k = 0; k < 300; k++) begin
         ra = {$urandom, $urandom};
         ra[12:3] = 10'($urandom_range(0, 31));
         step(1'b1, 2'($urandom_range(0, 3)), ra, {$urandom, $urandom});
      end
      drain();

      // The stall window at counter value 7 after reset.
      do_reset();
      idle(7);
      step(1'b1, C_LOAD, 64'h40, 64'd0);
`ifdef DMEM_STALL_EN
      check("t6_stall", obs_resp, 4'd0);
`else
      check("t6_nostall", obs_resp, 4'd1);
`endif
      step(1'b1, C_LOAD, 64'h40, 64'd0);
`ifdef DMEM_STALL_EN
      check("t6_after", obs_resp, 4'd1);
`else
      check("t6_after", obs_resp, 4'd2);
`endif
      drain();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
